addsum_drain: RTL and testbench

Read-out stage directly downstream of the accumulation sum RAM. After a layer's partial sums are complete, it sweeps a contiguous address range of that RAM through its read port. Each 32-bit signed sum passes through bias add, optional ReLU, rounding right-shift and saturation, and leaves as a narrow quantized stream with valid/ready backpressure. The output feeds the obuf/DDR write path.

---
 rtl/addsum_drain.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_addsum_drain.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsum_drain.sv
// -----------------------------------------------------------------------------
// addsum_drain
//
// Read-out stage for the accumulation sum RAM. When a layer's partial sums are
// complete, one I_start pulse sweeps a contiguous address range of the RAM. Each
// signed accumulator word is processed as follows:
//   - the latched bias is added
//   - negatives are optionally clamped to zero (ReLU)
//   - the word is rounded half up and arithmetically right-shifted
//   - the result is saturated to the narrow output width
// The quantized words are streamed out through a small first-word-fall-through
// FIFO with valid/ready backpressure.
//
// Handshake: a word moves downstream on every rising edge where O_dv and
// I_ready are both high. O_dv never drops and O_dout never changes while a word
// is waiting (O_dv=1, I_ready=0). Reads are credit-limited so the FIFO cannot
// overflow and no word is ever dropped.
//
// Ports
//   I_clk, I_rst          clock, synchronous active-high reset
//   I_start               one-cycle start pulse (honoured only in IDLE)
//   I_base_addr, I_len    first RAM address, number of words to drain
//   I_bias, I_shift       signed bias, rounding right-shift amount
//   I_relu_en             clamp negatives to zero
//   O_busy, O_done        run in progress / one-cycle completion pulse
//   O_raddr, O_rd         sum RAM read address and read enable
//   I_rdata               sum RAM data, valid one cycle after O_rd
//   O_dout, O_dv, I_ready output stream
//   dbg_state             current FSM state (IDLE=0 READ=1 FLUSH=2 DONE=3)
// -----------------------------------------------------------------------------
module addsum_drain #(
  parameter int C_DSIZE      = 32,
  parameter int C_ASIZE      = 10,
  parameter int C_LENSIZE    = 9,
  parameter int C_ODSIZE     = 8,
  parameter int C_SHSIZE     = 5,
  parameter int C_FIFO_DEPTH = 8
) (
  input  logic                 I_clk,
  input  logic                 I_rst,
  input  logic                 I_start,
  input  logic [C_ASIZE-1:0]   I_base_addr,
  input  logic [C_LENSIZE-1:0] I_len,
  input  logic [C_DSIZE-1:0]   I_bias,
  input  logic [C_SHSIZE-1:0]  I_shift,
  input  logic                 I_relu_en,
  output logic                 O_busy,
  output logic                 O_done,
  output logic [C_ASIZE-1:0]   O_raddr,
  output logic                 O_rd,
  input  logic [C_DSIZE-1:0]   I_rdata,
  output logic [C_ODSIZE-1:0]  O_dout,
  output logic                 O_dv,
  input  logic                 I_ready,
  output logic [1:0]           dbg_state
);

  // S1 holds the bias sum one bit wider than the accumulator so it cannot
  // overflow; S2 arithmetic gets one more bit for the rounding increment.
  localparam int SUM_W = C_DSIZE + 1;
  localparam int RND_W = C_DSIZE + 2;
  localparam int FAW   = $clog2(C_FIFO_DEPTH);
  localparam int CNT_W = FAW + 1;
  // Outstanding = four pipeline flags + FIFO count; two extra bits of headroom.
  localparam int OUT_W = CNT_W + 2;

  localparam int SAT_HI = (1 << (C_ODSIZE - 1)) - 1;
  localparam int SAT_LO = -(1 << (C_ODSIZE - 1));
  localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'(SAT_HI);
  localparam logic signed [RND_W-1:0] SAT_MIN = RND_W'(SAT_LO);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                state;
  logic [C_LENSIZE-1:0]  remaining;
  logic [C_DSIZE-1:0]    bias_q;
  logic [C_SHSIZE-1:0]   shift_q;
  logic                  relu_q;

  // Pipeline valid flags: rdata_v marks the cycle I_rdata carries a word.
  logic                  rdata_v;
  logic                  s1_v;
  logic signed [SUM_W-1:0] s1_sum;
  logic                  s2_v;
  logic [C_ODSIZE-1:0]   s2_data;

  // FIFO
  logic [C_ODSIZE-1:0]   fifo_mem [C_FIFO_DEPTH];
  logic [FAW-1:0]        wr_ptr;
  logic [FAW-1:0]        rd_ptr;
  logic [CNT_W-1:0]      fifo_cnt;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;

  logic [OUT_W-1:0]      outstanding;
  logic                  can_issue;
  logic                  drain_done;

  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Credit accounting. Every word that has been requested but not yet handed
  // downstream holds one FIFO slot. A new read is only issued when a slot is
  // still free for it, so the pipeline can always drain into the FIFO.
  // ---------------------------------------------------------------------------
  assign outstanding = OUT_W'(fifo_cnt) + OUT_W'(O_rd) + OUT_W'(rdata_v)
                     + OUT_W'(s1_v) + OUT_W'(s2_v);
  assign can_issue   = (outstanding < OUT_W'(C_FIFO_DEPTH));

  // The run is complete when nothing is in flight and the FIFO is either empty
  // or handing over its last word on this edge.
  assign drain_done = !O_rd && !rdata_v && !s1_v && !s2_v &&
                      ((fifo_cnt == '0) ||
                       ((fifo_cnt == CNT_W'(1)) && pop));

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state     <= ST_IDLE;
      O_rd      <= 1'b0;
      O_raddr   <= '0;
      O_busy    <= 1'b0;
      O_done    <= 1'b0;
      remaining <= '0;
      bias_q    <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          O_rd   <= 1'b0;
          O_done <= 1'b0;
          if (I_start) begin
            bias_q  <= I_bias;
            shift_q <= I_shift;
            relu_q  <= I_relu_en;
            if (I_len == '0) begin
              state  <= ST_DONE;
              O_done <= 1'b1;
            end else begin
              // The pipeline is empty in IDLE, so the first read needs no
              // credit check. O_raddr doubles as the running address.
              O_rd      <= 1'b1;
              O_raddr   <= I_base_addr;
              remaining <= I_len - C_LENSIZE'(1);
              O_busy    <= 1'b1;
              state     <= (I_len == C_LENSIZE'(1)) ? ST_FLUSH : ST_READ;
            end
          end
        end

        ST_READ: begin
          if (can_issue) begin
            O_rd      <= 1'b1;
            O_raddr   <= O_raddr + C_ASIZE'(1);  // wraps modulo 2^C_ASIZE
            remaining <= remaining - C_LENSIZE'(1);
            if (remaining == C_LENSIZE'(1)) begin
              state <= ST_FLUSH;
            end
          end else begin
            O_rd <= 1'b0;
          end
        end

        ST_FLUSH: begin
          O_rd <= 1'b0;
          if (drain_done) begin
            state  <= ST_DONE;
            O_done <= 1'b1;
            O_busy <= 1'b0;
          end
        end

        ST_DONE: begin
          O_done <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // S2 arithmetic: ReLU, round half up, arithmetic shift, saturate
  // ---------------------------------------------------------------------------
  logic signed [RND_W-1:0] relu_val;
  logic signed [RND_W-1:0] round_inc;
  logic signed [RND_W-1:0] rounded;
  logic signed [RND_W-1:0] shifted;
  logic [C_ODSIZE-1:0]     sat_val;

  always_comb begin
    relu_val = {s1_sum[SUM_W-1], s1_sum};
    if (relu_q && s1_sum[SUM_W-1]) begin
      relu_val = '0;
    end

    round_inc = '0;
    if (shift_q != '0) begin
      round_inc = RND_W'(1) << (shift_q - C_SHSIZE'(1));
    end

    rounded = relu_val + round_inc;
    shifted = rounded >>> shift_q;

    if (shifted > SAT_MAX) begin
      sat_val = SAT_MAX[C_ODSIZE-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_val = SAT_MIN[C_ODSIZE-1:0];
    end else begin
      sat_val = shifted[C_ODSIZE-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath pipeline: RAM read -> S1 (bias) -> S2 (quantize) -> FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      rdata_v <= 1'b0;
      s1_v    <= 1'b0;
      s1_sum  <= '0;
      s2_v    <= 1'b0;
      s2_data <= '0;
    end else begin
      rdata_v <= O_rd;
      s1_v    <= rdata_v;
      s1_sum  <= $signed({I_rdata[C_DSIZE-1], I_rdata}) +
                 $signed({bias_q[C_DSIZE-1], bias_q});
      s2_v    <= s1_v;
      s2_data <= sat_val;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO, first-word-fall-through
  // ---------------------------------------------------------------------------
  assign fifo_full = (fifo_cnt == CNT_W'(C_FIFO_DEPTH));
  assign O_dv      = (fifo_cnt != '0);
  assign pop       = O_dv && I_ready;
  // The credit check keeps the FIFO from being full when S2 delivers. The
  // guard still allows a write into a full FIFO that is popping this cycle.
  assign push      = s2_v && (!fifo_full || pop);
  // Gate the head word so O_dout reads 0 whenever nothing is valid.
  assign O_dout    = O_dv ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge I_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= s2_data;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FAW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FAW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_addsum_drain.sv
// -----------------------------------------------------------------------------
// Testbench for addsum_drain. A behavioural sum RAM answers reads one cycle
// after O_rd. A negedge monitor logs reads, accepted words and done pulses into
// queues. The directed vector table supplies hand-computed expected words.
// Hand-written sequences cover these scenarios:
//   - backpressure
//   - a zero-length start
//   - a start pulse while a run is in progress
//   - reset in the middle of a run
// -----------------------------------------------------------------------------
module tb_addsum_drain;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int LW = 9;
  localparam int OW = 8;
  localparam int SW = 5;
  localparam int FD = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] len = '0;
  logic [DW-1:0] bias = '0;
  logic [SW-1:0] shift = '0;
  logic          relu_en = 1'b0;
  logic          busy;
  logic          done;
  logic [AW-1:0] raddr;
  logic          rd;
  logic [DW-1:0] rdata;
  logic [OW-1:0] dout;
  logic          dv;
  logic          ready = 1'b1;
  logic [1:0]    dbg_state;

  addsum_drain #(
    .C_DSIZE(DW), .C_ASIZE(AW), .C_LENSIZE(LW), .C_ODSIZE(OW),
    .C_SHSIZE(SW), .C_FIFO_DEPTH(FD)
  ) dut (
    .I_clk(clk), .I_rst(rst), .I_start(start), .I_base_addr(base_addr),
    .I_len(len), .I_bias(bias), .I_shift(shift), .I_relu_en(relu_en),
    .O_busy(busy), .O_done(done), .O_raddr(raddr), .O_rd(rd),
    .I_rdata(rdata), .O_dout(dout), .O_dv(dv), .I_ready(ready),
    .dbg_state(dbg_state)
  );

  // ---------------- sum RAM model ----------------
  logic [DW-1:0] ram [1 << AW];
  always @(posedge clk) begin
    if (rd) rdata <= ram[raddr];
  end

  // ---------------- monitor ----------------
  logic [AW-1:0] raddr_q[$];
  int            rd_cyc_q[$];
  logic [OW-1:0] got_q[$];
  int            dv_cyc_q[$];
  int            done_cyc_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (rd) begin
        raddr_q.push_back(raddr);
        rd_cyc_q.push_back(cyc);
      end
      if (dv && ready) begin
        got_q.push_back(dout);
        dv_cyc_q.push_back(cyc);
      end
      if (done) done_cyc_q.push_back(cyc);
    end
  end

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int got_at(input int i);
    if (i < got_q.size()) return int'(got_q[i]);
    return -1;
  endfunction

  function automatic int raddr_at(input int i);
    if (i < raddr_q.size()) return int'(raddr_q[i]);
    return -1;
  endfunction

  function automatic int int_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [AW-1:0]          base;
    logic [LW-1:0]          len;
    logic [DW-1:0]          bias;
    logic [SW-1:0]          shift;
    logic                   relu;
    logic [3:0][DW-1:0]     w;
    logic [3:0][OW-1:0]     e;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic [AW-1:0] b, input logic [LW-1:0] l, input logic [DW-1:0] bi,
    input logic [SW-1:0] sh, input logic re,
    input logic [DW-1:0] w0, input logic [DW-1:0] w1,
    input logic [DW-1:0] w2, input logic [DW-1:0] w3,
    input logic [OW-1:0] e0, input logic [OW-1:0] e1,
    input logic [OW-1:0] e2, input logic [OW-1:0] e3);
    vec_t v;
    v.base = b; v.len = l; v.bias = bi; v.shift = sh; v.relu = re;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  // Pulses I_start for one cycle and returns T (the cycle it is sampled in).
  // Afterwards the config inputs are scrambled: the run must use latched copies.
  task automatic do_start(input logic [AW-1:0] b, input logic [LW-1:0] l,
                          input logic [DW-1:0] bi, input logic [SW-1:0] sh,
                          input logic re, output int t);
    @(posedge clk); #1;
    base_addr = b; len = l; bias = bi; shift = sh; relu_en = re;
    start = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = ~b; len = l + LW'(7); bias = bi + DW'(100);
    shift = sh + SW'(3); relu_en = ~re;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_vec(input int idx, input bit timing);
    vec_t v;
    int t, r0, rc0, g0, d0, dc0, n;
    bit ok;
    logic [AW-1:0] a;
    v = vecs[idx];
    n = int'(v.len);
    for (int k = 0; k < n; k++) begin
      a = v.base + AW'(k);
      ram[a] = v.w[k];
      exp_q.push_back(v.e[k]);
    end
    r0 = raddr_q.size(); rc0 = rd_cyc_q.size(); g0 = got_q.size();
    d0 = dv_cyc_q.size(); dc0 = done_cyc_q.size();
    do_start(v.base, v.len, v.bias, v.shift, v.relu, t);
    wait_done(200, ok);
    check($sformatf("v%0d done_seen", idx), int'(ok), 1);
    repeat (2) @(negedge clk);
    check($sformatf("v%0d read_count", idx), raddr_q.size() - r0, n);
    check($sformatf("v%0d word_count", idx), got_q.size() - g0, n);
    check($sformatf("v%0d done_count", idx), done_cyc_q.size() - dc0, 1);
    for (int k = 0; k < n; k++) begin
      a = v.base + AW'(k);
      check($sformatf("v%0d raddr[%0d]", idx, k), raddr_at(r0 + k), int'(a));
      check($sformatf("v%0d dout[%0d]", idx, k), got_at(g0 + k),
            int'(exp_q.pop_front()));
    end
    if (timing) begin
      check("first_rd_cycle", int_at(rd_cyc_q, rc0), t + 1);
      check("last_rd_cycle", int_at(rd_cyc_q, rc0 + n - 1), t + n);
      check("first_dv_cycle", int_at(dv_cyc_q, d0), t + 5);
      check("last_dv_cycle", int_at(dv_cyc_q, d0 + n - 1), t + 4 + n);
      check("done_cycle", int_at(done_cyc_q, dc0), t + 5 + n);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the summary, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int t, r0, g0, dc0, stable_err;
    bit ok, held_v;
    logic [OW-1:0] held;
    logic [AW-1:0] a;

    vecs[0]  = mk(10'd0, 9'd4, 32'd4, 5'd2, 1'b0,
                  32'd100, 32'd0, -32'sd8, 32'd7, 8'd26, 8'd1, 8'hFF, 8'd3);
    vecs[1]  = mk(10'd100, 9'd1, 32'd24, 5'd3, 1'b0,
                  32'd1000, 32'd0, 32'd0, 32'd0, 8'd127, 8'd0, 8'd0, 8'd0);
    vecs[2]  = mk(10'd100, 9'd1, 32'd0, 5'd0, 1'b0,
                  -32'sd300, 32'd0, 32'd0, 32'd0, 8'h80, 8'd0, 8'd0, 8'd0);
    vecs[3]  = mk(10'd100, 9'd1, 32'd0, 5'd1, 1'b0,
                  -32'sd5, 32'd0, 32'd0, 32'd0, 8'hFE, 8'd0, 8'd0, 8'd0);
    vecs[4]  = mk(10'd100, 9'd1, 32'd24, 5'd3, 1'b1,
                  32'd1000, 32'd0, 32'd0, 32'd0, 8'd127, 8'd0, 8'd0, 8'd0);
    vecs[5]  = mk(10'd100, 9'd1, 32'd0, 5'd0, 1'b1,
                  -32'sd300, 32'd0, 32'd0, 32'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    vecs[6]  = mk(10'd100, 9'd1, 32'd0, 5'd1, 1'b1,
                  -32'sd5, 32'd0, 32'd0, 32'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    vecs[7]  = mk(10'd1022, 9'd4, 32'd0, 5'd0, 1'b0,
                  32'd1, -32'sd1, 32'd200, -32'sd200, 8'd1, 8'hFF, 8'h7F, 8'h80);
    vecs[8]  = mk(10'd300, 9'd4, -32'sd1, 5'd1, 1'b0,
                  32'd2, 32'd3, -32'sd2, 32'd0, 8'd1, 8'd1, 8'hFF, 8'd0);
    vecs[9]  = mk(10'd400, 9'd2, 32'd0, 5'd31, 1'b0,
                  32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'd0, 8'd1, 8'hFF, 8'd0, 8'd0);
    vecs[10] = mk(10'd500, 9'd3, -32'sd10, 5'd2, 1'b1,
                  32'd5, 32'd20, 32'd11, 32'd0, 8'd0, 8'd3, 8'd0, 8'd0);

    // Reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset rd", int'(rd), 0);
    check("reset raddr", int'(raddr), 0);
    check("reset dv", int'(dv), 0);
    check("reset dout", int'(dout), 0);
    check("reset state", int'(dbg_state), 0);

    // Table-driven vectors with I_ready held high; vector 0 also checks timing.
    ready = 1'b1;
    for (int i = 0; i < NVEC; i++) run_vec(i, i == 0);

    // Zero-length start: done at T+1, no reads, no words, busy stays low.
    r0 = raddr_q.size(); g0 = got_q.size(); dc0 = done_cyc_q.size();
    do_start(10'd5, 9'd0, 32'd0, 5'd0, 1'b0, t);
    @(negedge clk);
    check("len0 done_at_T+1", int'(done), 1);
    check("len0 busy", int'(busy), 0);
    repeat (6) @(negedge clk);
    check("len0 reads", raddr_q.size() - r0, 0);
    check("len0 words", got_q.size() - g0, 0);
    check("len0 done_count", done_cyc_q.size() - dc0, 1);

    // Backpressure: 20 words, I_ready low for 30 cycles, stray start mid-run.
    ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      a = AW'(200 + k);
      ram[a] = DW'(k * 5 - 40);
      exp_q.push_back(OW'(k * 5 - 40));
    end
    r0 = raddr_q.size(); g0 = got_q.size(); dc0 = done_cyc_q.size();
    do_start(10'd200, 9'd20, 32'd0, 5'd0, 1'b0, t);
    stable_err = 0; held_v = 1'b0; held = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dv) begin
        if (!held_v) begin
          held_v = 1'b1;
          held = dout;
        end else if (dout != held) begin
          stable_err++;
        end
      end
      if (i == 10) begin
        start = 1'b1; base_addr = 10'd0; len = 9'd5;
      end else begin
        start = 1'b0;
      end
    end
    check("bp reads_while_stalled", raddr_q.size() - r0, FD);
    check("bp dv_while_stalled", int'(dv), 1);
    check("bp dout_unstable_cycles", stable_err, 0);
    check("bp held_word", int'(held), int'(exp_q[0]));
    ready = 1'b1;
    wait_done(300, ok);
    check("bp done_seen", int'(ok), 1);
    repeat (10) @(negedge clk);
    check("bp read_count", raddr_q.size() - r0, 20);
    check("bp word_count", got_q.size() - g0, 20);
    check("bp done_count", done_cyc_q.size() - dc0, 1);
    check("bp idle_after", int'(busy), 0);
    for (int k = 0; k < 20; k++) begin
      check($sformatf("bp raddr[%0d]", k), raddr_at(r0 + k), 200 + k);
      check($sformatf("bp dout[%0d]", k), got_at(g0 + k), int'(exp_q.pop_front()));
    end

    // Reset mid-run with 5 words sitting in the FIFO (cycle T+9, ready low).
    ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      a = AW'(600 + k);
      ram[a] = DW'(k + 1);
    end
    g0 = got_q.size(); dc0 = done_cyc_q.size();
    do_start(10'd600, 9'd12, 32'd0, 5'd0, 1'b0, t);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst dv", int'(dv), 0);
    check("rst busy", int'(busy), 0);
    check("rst rd", int'(rd), 0);
    check("rst state", int'(dbg_state), 0);
    ready = 1'b1;
    repeat (15) @(negedge clk);
    check("rst no_done", done_cyc_q.size() - dc0, 0);
    check("rst no_words", got_q.size() - g0, 0);

    // A fresh run after the reset must deliver correct data.
    run_vec(0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
